// File: rtl/zaxxon_sound_latch.sv
`default_nettype none
// ============================================================================
//  Module   : zaxxon_sound_latch
//  Purpose  : CPU-facing sound PPI (8255-style) with three 8-bit latches plus
//             a control register. Port A (active-low) is turned into the
//             active-high trig[7:0] vector: level bits pass through, pulse
//             bits become retriggerable one-shots that mimic the 555s.
//  Revision : 1.0  initial release
// ============================================================================
module zaxxon_sound_latch #(
  parameter logic [7:0]    PULSE_MASK = 8'hF0,
  parameter int            CW         = 20,
  parameter logic [CW-1:0] PULSE_LEN  = 20'd480000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] trig,
  output logic [7:0] port_b,
  output logic [7:0] port_c
);

  localparam logic [CW-1:0] c_cnt_one  = 1;
  localparam logic [CW-1:0] c_cnt_zero = '0;

  logic       r_wr_q;
  logic       r_armed;
  logic       w_wr_evt;
  logic [7:0] r_port_a;
  logic [7:0] r_port_b;
  logic [7:0] r_port_c;
  logic [7:0] w_trig;

  // A strobe still high out of reset must drop once before it can write,
  // so r_armed only sets after wr has been observed low.
  assign w_wr_evt = cs & wr & ~r_wr_q & r_armed;

  // Write-strobe edge history and the post-reset arming flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_q  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_wr_q <= wr;
      if (!wr) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Port latches: direct writes, mode set (all off) and port C bit set/reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_port_a <= 8'hFF;
      r_port_b <= 8'hFF;
      r_port_c <= 8'hFF;
    end else if (w_wr_evt) begin
      case (addr)
        2'd0: r_port_a <= din;
        2'd1: r_port_b <= din;
        2'd2: r_port_c <= din;
        default: begin
          if (din[7]) begin
            // Mode bits are not modelled; a mode set just silences everything.
            r_port_a <= 8'hFF;
            r_port_b <= 8'hFF;
            r_port_c <= 8'hFF;
          end else begin
            r_port_c[din[3:1]] <= din[0];
          end
        end
      endcase
    end
  end

  // Read mux; cs deliberately does not gate the read path.
  always_comb begin
    dout = 8'hFF;
    case (addr)
      2'd0:    dout = r_port_a;
      2'd1:    dout = r_port_b;
      2'd2:    dout = r_port_c;
      default: dout = 8'hFF;
    endcase
  end

  // Per-bit trigger generation, level or one-shot depending on PULSE_MASK.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (PULSE_MASK[i]) begin : g_pulse
      logic          r_prev;
      logic [CW-1:0] r_cnt;
      logic          r_trig;
      logic          w_fall;
      logic [CW-1:0] w_cnt_nxt;

      assign w_fall = r_prev & ~r_port_a[i];

      // Load wins over decrement so a retrigger on the expiry cycle leaves no gap.
      always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_fall) begin
          w_cnt_nxt = PULSE_LEN;
        end else if (r_cnt != c_cnt_zero) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end

      // Edge history resets high so leaving reset never fires a pulse.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_prev <= 1'b1;
          r_cnt  <= c_cnt_zero;
          r_trig <= 1'b0;
        end else begin
          r_prev <= r_port_a[i];
          r_cnt  <= w_cnt_nxt;
          r_trig <= (w_cnt_nxt != c_cnt_zero);
        end
      end

      assign w_trig[i] = r_trig;
    end else begin : g_level
      logic r_trig;

      // Level bit: registered inversion of the active-low latch bit.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_trig <= 1'b0;
        end else begin
          r_trig <= ~r_port_a[i];
        end
      end

      assign w_trig[i] = r_trig;
    end
  end

  assign trig   = w_trig;
  assign port_b = r_port_b;
  assign port_c = r_port_c;

endmodule
`default_nettype wire

// File: tb/tb_zaxxon_sound_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zaxxon_sound_latch
//  Purpose  : Self-checking bench for zaxxon_sound_latch (PULSE_LEN = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_zaxxon_sound_latch;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs      = 1'b0;
  logic       wr      = 1'b0;
  logic [1:0] addr    = 2'd0;
  logic [7:0] din     = 8'h00;
  logic [7:0] dout;
  logic [7:0] trig;
  logic [7:0] port_b;
  logic [7:0] port_c;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] ed;
    logic [7:0] eb;
    logic [7:0] ec;
  } pstep_t;

  logic [7:0] q_trig[$];
  pstep_t     q_port[$];

  zaxxon_sound_latch #(
    .PULSE_MASK (8'hF0),
    .CW         (20),
    .PULSE_LEN  (20'd16)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cs      (cs),
    .wr      (wr),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .trig    (trig),
    .port_b  (port_b),
    .port_c  (port_c)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    logic [7:0] e;
    pstep_t     p;
    reset_n = 1'b0; cs = 1'b1; wr = 1'b1; addr = 2'd0; din = 8'h00;
    q_trig.push_back(8'h00);
    q_port.push_back('{2'd0, 8'h00, 2'd0, 8'hFF, 8'hFF, 8'hFF});
    repeat (3) @(posedge clk_sys);
    #1;
    e = q_trig.pop_front();
    p = q_port.pop_front();
    n_vec++; if (trig !== e) begin n_bad++; $display("FAIL reset_trig got %h want %h", trig, e); end
    n_vec++; if (port_b !== p.eb) begin n_bad++; $display("FAIL reset_port_b got %h want %h", port_b, p.eb); end
    n_vec++; if (port_c !== p.ec) begin n_bad++; $display("FAIL reset_port_c got %h want %h", port_c, p.ec); end
    n_vec++; if (dout !== p.ed) begin n_bad++; $display("FAIL reset_dout got %h want %h", dout, p.ed); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      q_trig.push_back(8'h00);
      q_port.push_back('{2'd0, 8'h00, 2'd0, 8'hFF, 8'hFF, 8'hFF});
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      p = q_port.pop_front();
      n_vec++; if (dout !== p.ed) begin n_bad++; $display("FAIL release_no_write c=%0d dout got %h want %h", c, dout, p.ed); end
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL release_trig c=%0d got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_level();
    logic [7:0] e;
    for (int c = 0; c < 10; c++) begin
      cs   = (c == 0 || c == 5);
      wr   = (c == 0 || c == 5);
      addr = 2'd0;
      din  = (c == 0) ? 8'hFE : 8'hFF;
      q_trig.push_back((c >= 1 && c <= 5) ? 8'h01 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL level c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [7:0] e;
    for (int c = 0; c < 24; c++) begin
      cs   = (c < 10) || (c == 20);
      wr   = (c < 10) || (c == 20);
      addr = 2'd0;
      din  = (c < 10) ? 8'hEF : 8'hFF;
      q_trig.push_back((c >= 1 && c <= 16) ? 8'h10 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL one_shot c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int c = 0; c < 30; c++) begin
      cs   = (c == 0 || c == 5 || c == 10 || c == 28);
      wr   = cs;
      addr = 2'd0;
      din  = (c == 5 || c == 28) ? 8'hFF : 8'hEF;
      q_trig.push_back((c >= 1 && c <= 26) ? 8'h10 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL retrigger c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_expiry_retrigger();
    logic [7:0] e;
    for (int c = 0; c < 36; c++) begin
      cs   = (c == 0 || c == 5 || c == 16 || c == 34);
      wr   = cs;
      addr = 2'd0;
      din  = (c == 5 || c == 34) ? 8'hFF : 8'hEF;
      q_trig.push_back((c >= 1 && c <= 32) ? 8'h10 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL expiry_retrigger c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_mode_set_keeps_pulse();
    logic [7:0] e;
    for (int c = 0; c < 20; c++) begin
      cs   = (c == 0 || c == 4);
      wr   = cs;
      addr = (c == 4) ? 2'd3 : 2'd0;
      din  = (c == 4) ? 8'h80 : 8'h7F;
      q_trig.push_back((c >= 1 && c <= 16) ? 8'h80 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL mode_set_pulse c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_port_c();
    pstep_t steps[8];
    pstep_t p;
    steps[0] = '{2'd3, 8'h07, 2'd2, 8'hFF, 8'hFF, 8'hFF};
    steps[1] = '{2'd3, 8'h06, 2'd2, 8'hF7, 8'hFF, 8'hF7};
    steps[2] = '{2'd3, 8'h0E, 2'd2, 8'h77, 8'hFF, 8'h77};
    steps[3] = '{2'd3, 8'h0F, 2'd2, 8'hF7, 8'hFF, 8'hF7};
    steps[4] = '{2'd1, 8'h5A, 2'd1, 8'h5A, 8'h5A, 8'hF7};
    steps[5] = '{2'd2, 8'h3C, 2'd2, 8'h3C, 8'h5A, 8'h3C};
    steps[6] = '{2'd0, 8'hF5, 2'd3, 8'hFF, 8'h5A, 8'h3C};
    steps[7] = '{2'd3, 8'h80, 2'd0, 8'hFF, 8'hFF, 8'hFF};
    for (int s = 0; s < 8; s++) begin
      cs = 1'b1; wr = 1'b1; addr = steps[s].wa; din = steps[s].wd;
      q_port.push_back(steps[s]);
      @(posedge clk_sys); #1;
      cs = 1'b0; wr = 1'b0; addr = steps[s].ra;
      #1;
      p = q_port.pop_front();
      n_vec++; if (dout !== p.ed) begin n_bad++; $display("FAIL ports s=%0d dout got %h want %h", s, dout, p.ed); end
      n_vec++; if (port_b !== p.eb) begin n_bad++; $display("FAIL ports s=%0d port_b got %h want %h", s, port_b, p.eb); end
      n_vec++; if (port_c !== p.ec) begin n_bad++; $display("FAIL ports s=%0d port_c got %h want %h", s, port_c, p.ec); end
      @(posedge clk_sys); #1;
    end
    addr = 2'd0;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset_mid_pulse();
    logic [7:0] e;
    for (int c = 0; c < 9; c++) begin
      cs   = (c == 0);
      wr   = cs;
      addr = 2'd0;
      din  = 8'h7F;
      q_trig.push_back((c >= 1) ? 8'h80 : 8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL mid_pulse_pre c=%0d trig got %h want %h", c, trig, e); end
    end
    cs = 1'b0; wr = 1'b0;
    #2;
    reset_n = 1'b0;
    q_trig.push_back(8'h00);
    #1;
    e = q_trig.pop_front();
    n_vec++; if (trig !== e) begin n_bad++; $display("FAIL async_reset_trig got %h want %h", trig, e); end
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      q_trig.push_back(8'h00);
      @(posedge clk_sys); #1;
      e = q_trig.pop_front();
      n_vec++; if (trig !== e) begin n_bad++; $display("FAIL post_reset c=%0d trig got %h want %h", c, trig, e); end
      n_vec++; if (dout !== 8'hFF) begin n_bad++; $display("FAIL post_reset c=%0d dout got %h want ff", c, dout); end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_one_shot();
    test_back_to_back();
    test_expiry_retrigger();
    test_mode_set_keeps_pulse();
    test_port_c();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zaxxon_sound_latch.md
Name: zaxxon_sound_latch

Overview:
- CPU-facing sound command stage, directly upstream of the discrete sound generator.
- Emulates the 8255-style sound PPI: three write/readable 8-bit ports plus a control register.
- Converts the active-low port A bits into the active-high trig[7:0] vector the generator consumes: level bits pass through, pulse bits become retriggerable one-shots that emulate the board's 555 monostables.
- Port B and port C latches are exported for other sound stages.

Parameters:
- PULSE_MASK, 8'hF0, bit i=1 makes trig[i] a one-shot; bit i=0 makes it a level pass-through.
- PULSE_LEN, 20'd480000, one-shot length in clk_sys cycles (10 ms at 48 MHz); must be ≥1.
- CW, 20, one-shot counter width; PULSE_LEN must fit in CW bits.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select for the sound PPI.
- wr  in  1  write strobe, active high, may last multiple cycles.
- addr  in  2  register select: 0=A, 1=B, 2=C, 3=control.
- din  in  8  CPU write data.
- dout  out  8  read data for the addressed port.
- trig  out  8  active-high trigger vector to the discrete sound generator.
- port_b  out  8  port B latch.
- port_c  out  8  port C latch.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - port A, port B and port C latches = 8'hFF (all sounds off, active-low).
  - wr edge register = 0.
  - all one-shot counters = 0.
  - trig = 8'h00; dout = 8'hFF.
- Write detect:
  - wr_q is wr delayed one cycle.
  - A write event occurs on a cycle where cs & wr & ~wr_q.
  - Exactly one write per strobe regardless of strobe length.
  - A strobe already high when reset releases produces no write (wr_q resets to 0, but wr must see a low→high transition after reset; implement with a reset-armed flag).
- Write decode (latch updates at the clock edge of the write event):
  - addr 0/1/2: port A/B/C ← din.
  - addr 3, din[7]=1 (mode set): A, B, C ← 8'hFF. Mode bits are ignored.
  - addr 3, din[7]=0 (bit set/reset): port C bit din[3:1] ← din[0]. Other C bits unchanged.
- Read:
  - dout is combinational from addr: 0→A, 1→B, 2→C, 3→8'hFF.
  - cs does not gate dout.
- trig generation (registered, one cycle after the latch changes):
  - Level bit (PULSE_MASK[i]=0): trig[i] = ~A[i].
  - Pulse bit (PULSE_MASK[i]=1):
    - A falling edge on A[i] (previous registered value 1, new value 0) loads cnt[i] = PULSE_LEN.
    - Otherwise, if cnt[i]≠0, cnt[i] decrements by 1.
    - trig[i] = (cnt[i]≠0), registered.
    - High for exactly PULSE_LEN cycles after an isolated edge.
  - Retrigger: a falling edge while cnt[i]≠0 reloads PULSE_LEN; the pulse is extended with no gap.
  - A rising edge, or holding A[i]=0, does not retrigger or cancel the pulse.
  - A mode set that returns A to FF does not cancel running pulses.
  - Edge history register prevA resets to 8'hFF, so leaving reset never fires a pulse.
- Simultaneous events: a write to A and a counter expiring in the same cycle are resolved with load taking priority over decrement.
- Reset mid-pulse: counters and trig clear immediately. No pulse resumes after reset_n rises.

Test Plan:
1. Reset check: hold reset_n=0 with wr=1, cs=1 → trig=00, port_b=FF, port_c=FF, dout(addr0)=FF. Release reset_n with wr still high → no write; A stays FF.
2. Level path, PULSE_MASK=F0: write addr0=8'hFE → one cycle later trig=8'h01 and it stays. Write 8'hFF → trig=00 on the following cycle.
3. One-shot, PULSE_LEN=16: write addr0=8'hEF → trig[4]=1 for exactly 16 cycles, then 0. A 10-cycle wr strobe still yields a single pulse.
4. Retrigger, PULSE_LEN=16: write EF, then FF at cycle 5, then EF at cycle 10 → trig[4] high continuously from first edge +1 to cycle 10+16.
5. Port C bit set/reset: write addr3=8'h07 → port_c=8'hFF with bit3 set. Write addr3=8'h06 → port_c=8'hF7. Write addr3=8'h80 → A=B=C=FF.
6. Reset mid-pulse: start pulse on bit 7, assert reset_n=0 at count 8 → trig=00 asynchronously and stays 0 after release.
